beep_driver: RTL



---
 rtl/beep_driver.sv | 133 +++++++++++++
 1 files changed

// File: rtl/beep_driver.sv
// Turns one-cycle request pulses into timed buzzer tones, queuing overlapping requests.
// Define BEEP_ACTIVE_LOW_EN to invert the beep pin for a PNP-driven buzzer.
module beep_driver #(
    parameter logic [23:0] TONE_HALF = 24'd12_499,
    parameter logic [23:0] BEEP_LEN  = 24'd4_999_999,
    parameter logic [23:0] GAP_LEN   = 24'd2_499_999,
    parameter logic [1:0]  PEND_MAX  = 2'd3
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       beep_req,
    input  logic       cancel,
    output logic       beep,
    output logic       busy,
    output logic [1:0] pend_cnt,
    output logic       req_drop
);

`ifdef BEEP_ACTIVE_LOW_EN
    localparam logic BEEP_IDLE = 1'b1;
`else
    localparam logic BEEP_IDLE = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

    state_t      state_q, state_d;
    logic [23:0] dur_q, dur_d;
    logic [23:0] half_q, half_d;
    logic        beep_q, beep_d;
    logic [1:0]  pend_q, pend_d;
    logic        drop_q, drop_d;

    always_comb begin
        state_d = state_q;
        dur_d   = dur_q;
        half_d  = half_q;
        beep_d  = beep_q;
        pend_d  = pend_q;
        drop_d  = 1'b0;

        if (cancel) begin
            state_d = IDLE;
            dur_d   = 24'd0;
            half_d  = 24'd0;
            beep_d  = BEEP_IDLE;
            pend_d  = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (beep_req) begin
                        state_d = TONE;
                        dur_d   = 24'd0;
                        half_d  = 24'd0;
                        beep_d  = ~BEEP_IDLE;
                    end
                end
                TONE: begin
                    if (beep_req) begin
                        if (pend_q < PEND_MAX) pend_d = pend_q + 2'd1;
                        else                   drop_d = 1'b1;
                    end
                    if (dur_q == BEEP_LEN) begin
                        state_d = GAP;
                        dur_d   = 24'd0;
                        half_d  = 24'd0;
                        beep_d  = BEEP_IDLE;
                    end else begin
                        dur_d = dur_q + 24'd1;
                        if (half_q == TONE_HALF) begin
                            half_d = 24'd0;
                            beep_d = ~beep_q;
                        end else begin
                            half_d = half_q + 24'd1;
                        end
                    end
                end
                GAP: begin
                    beep_d = BEEP_IDLE;
                    if (dur_q == GAP_LEN) begin
                        dur_d  = 24'd0;
                        half_d = 24'd0;
                        // A request landing on a dequeue cancels out (+1 -1).
                        if (pend_q != 2'd0) begin
                            state_d = TONE;
                            beep_d  = ~BEEP_IDLE;
                            if (!beep_req) pend_d = pend_q - 2'd1;
                        end else if (beep_req) begin
                            state_d = TONE;
                            beep_d  = ~BEEP_IDLE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        dur_d = dur_q + 24'd1;
                        if (beep_req) begin
                            if (pend_q < PEND_MAX) pend_d = pend_q + 2'd1;
                            else                   drop_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    beep_d  = BEEP_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            dur_q   <= 24'd0;
            half_q  <= 24'd0;
            beep_q  <= BEEP_IDLE;
            pend_q  <= 2'd0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dur_q   <= dur_d;
            half_q  <= half_d;
            beep_q  <= beep_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
        end
    end

    assign beep     = beep_q;
    assign busy     = (state_q != IDLE);
    assign pend_cnt = pend_q;
    assign req_drop = drop_q;

endmodule
